// File: rtl/pc_next_unit.sv
// Program-counter stage: sequential fetch, stall/wait-state holds, and branch/jump
// redirects, including redirects parked while instruction memory is busy.
// Optional macro PC_REDIRECT_COUNT_EN adds a saturating redirect_cnt output.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_busy,
  input  logic        branch_taken,
  input  logic [31:0] offset_ext,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, PENDING} state_t;

  // Handshake: there is no ready/valid pair here; imem_busy acts as the
  // memory's "not ready", and fetch_valid is only asserted in RUN while ready.
  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pend_target;
  logic [31:0] pend_next;
  logic [31:0] off_scaled;
  logic [31:0] branch_target;
  logic [31:0] jump_addr;
  logic [31:0] target;
  logic        redirect;
  logic        flush_next;

  assign pc_plus4      = pc + 32'(PC_STEP);
  assign off_scaled    = offset_ext << 2;
  assign branch_target = pc_plus4 + off_scaled;
  assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};
  assign target        = jump ? jump_addr : branch_target;
  assign redirect      = jump | branch_taken;
  assign fetch_valid   = (state == RUN) & ~imem_busy & ~reset;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend_target;
    flush_next = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect && !imem_busy) begin
          pc_next    = target;
          flush_next = 1'b1;
        end else if (redirect) begin
          pend_next  = target;
          state_next = PENDING;
        end else if (!(stall || imem_busy)) begin
          pc_next = pc_plus4;
        end
      end
      PENDING: begin
        // The parked redirect wins over any later one and ignores stall.
        if (!imem_busy) begin
          pc_next    = pend_target;
          flush_next = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pend_target <= 32'h0000_0000;
      flush       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_target <= pend_next;
      flush       <= flush_next;
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= 16'h0000;
    end else if (flush_next && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a vector table replayed through a scoreboard queue,
// followed by a randomized-length busy/pending sequence.
module tb_pc_next_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_busy;
  logic        branch_taken;
  logic [31:0] offset_ext;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] redirect_cnt;
`endif

  int checks;
  int errors;

  pc_next_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .imem_busy    (imem_busy),
    .branch_taken (branch_taken),
    .offset_ext   (offset_ext),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush)
`ifdef PC_REDIRECT_COUNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        busy;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] pc;
    logic        flush;
    logic        fv;
  } vec_t;

  localparam int W = 66;
  logic [W-1:0] exp_q[$];
  vec_t         tbl[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic busy,
                              input logic br, input logic [31:0] off, input logic jmp,
                              input logic [25:0] jt, input logic [31:0] epc,
                              input logic efl, input logic efv);
    vec_t v;
    v.rst = rst; v.stall = stl; v.busy = busy; v.br = br; v.off = off;
    v.jmp = jmp; v.jt = jt; v.pc = epc; v.flush = efl; v.fv = efv;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
    end
  endtask

  // driver + scoreboard: drive at negedge, push expectation, compare 1ns after posedge
  task automatic step(input vec_t v, input int row);
    logic [W-1:0] e;
    @(negedge clk);
    reset        = v.rst;
    stall        = v.stall;
    imem_busy    = v.busy;
    branch_taken = v.br;
    offset_ext   = v.off;
    jump         = v.jmp;
    jump_target  = v.jt;
    exp_q.push_back({v.pc, v.pc + 32'd4, v.flush, v.fv});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard row %0d: queue empty, expected 1 entry", row);
    end else begin
      e = exp_q.pop_front();
      check("pc", row, pc, e[65:34]);
      check("pc_plus4", row, pc_plus4, e[33:2]);
      check("flush", row, {31'd0, flush}, {31'd0, e[1]});
      check("fetch_valid", row, {31'd0, fetch_valid}, {31'd0, e[0]});
    end
  endtask

  initial begin
    int n;
    int row;
    checks = 0;
    errors = 0;
    reset = 1'b1; stall = 1'b0; imem_busy = 1'b0; branch_taken = 1'b0;
    offset_ext = 32'd0; jump = 1'b0; jump_target = 26'd0;

    //            rst stl bsy br  off            jmp jt           pc              fl  fv
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h10,        0, 26'h0,        32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0004, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0008, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_000C, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,        32'h0000_000C, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,        32'h0000_000C, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,         0, 26'h0,        32'h0000_000C, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         1, 26'h40,       32'h0000_0100, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 26'h0,        32'h0000_00FC, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0100, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         1, 26'h10_0004,  32'h0040_0010, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h10,        1, 26'h10_0000,  32'h0040_0000, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0040_0004, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         1, 26'h80,       32'h0000_0200, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 32'h10,        0, 26'h0,        32'h0000_0200, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h100,       0, 26'h0,        32'h0000_0200, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,         1, 26'h5,        32'h0000_0200, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0244, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0248, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         1, 26'h40,       32'h0000_0100, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFBE, 0, 26'h0,        32'hFFFF_FFFC, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,        32'hFFFF_FFFC, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,        32'hFFFF_FFFC, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0004, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 32'h10,        0, 26'h0,        32'h0000_0004, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,         0, 26'h0,        32'h0000_0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0004, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0000_0008, 0, 1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Hand-written: parked branch held for a random number of busy cycles.
    row = 100;
    step(mk(0, 0, 0, 0, 32'h0, 1, 26'hC0, 32'h0000_0300, 1, 1), row++);
    n = $urandom_range(1, 6);
    step(mk(0, 0, 1, 1, 32'h4, 0, 26'h0, 32'h0000_0300, 0, 0), row++);
    for (int k = 1; k < n; k++) begin
      step(mk(0, k[0], 1, k[1], 32'h40, 0, 26'h0, 32'h0000_0300, 0, 0), row++);
    end
    step(mk(0, 1, 0, 0, 32'h0, 0, 26'h0, 32'h0000_0314, 1, 1), row++);
    step(mk(0, 0, 0, 0, 32'h0, 1, 26'h40, 32'h0000_0100, 1, 1), row++);
    step(mk(0, 0, 0, 0, 32'h0, 0, 26'h0, 32'h0000_0104, 0, 1), row++);

`ifdef PC_REDIRECT_COUNT_EN
    check("redirect_cnt", row, {16'd0, redirect_cnt}, 32'd3);
    @(negedge clk);
    force dut.redirect_cnt = 16'hFFFF;
    step(mk(0, 1, 0, 0, 32'h0, 0, 26'h0, 32'h0000_0104, 0, 1), row++);
    release dut.redirect_cnt;
    step(mk(0, 0, 0, 0, 32'h0, 1, 26'h80, 32'h0000_0200, 1, 1), row++);
    check("redirect_cnt_sat", row, {16'd0, redirect_cnt}, 32'h0000_FFFF);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the stimulus is bounded, but never let the run hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
